beat_peak_detector: RTL and testbench
=====================================

// Module: beat_peak_detector
// PURPOSE
//  Consumes the match-filter output stream (one sample per ready strobe) and detects
//  heartbeat peaks using an adaptive threshold and a refractory window.
//  Emits a one-clock beat pulse, the beat-to-beat interval in samples and the heart rate in BPM.
//  Sits between fir128_match and the display/alarm logic.
// PARAMETERS
//  DATA_W      16    width of signed input sample y
//  FS_HZ       200   sample rate (ready strobes per second)
//  REFRACT     60    samples ignored after each beat (300 ms)
//  MAX_INTVL   600   samples with no beat before no_signal asserts (3 s)
//  DECAY_SHIFT 5     envelope decay per sample: env -= env>>>DECAY_SHIFT
//  MIN_THRESH  64    floor on detection threshold
// PORTS
//  clock          in   1       system clock
//  reset          in   1       synchronous, active-high
//  ready          in   1       new sample strobe; >=32 clocks between strobes
//  y              in   DATA_W  signed filtered sample, valid on ready
//  beat           out  1       one-clock pulse per detected peak
//  interval       out  16      samples between last two beats
//  interval_valid out  1       one-clock pulse with each new interval
//  bpm            out  8       (60*FS_HZ)/interval, saturated at 255
//  bpm_valid      out  1       level: bpm holds a current value
//  no_signal      out  1       level: MAX_INTVL samples elapsed without a beat
// BEHAVIOUR
//  - Reset: all outputs 0. env=0, cnt=0, have_prev=0, state=SEARCH.
//  - All sample processing occurs only in clocks where ready=1.
//    Divider and output logic run every clock.
//  - Envelope: if y>env then env<=y, else env<=env-(env>>>DECAY_SHIFT).
//    Negative y never raises env.
//  - Threshold: thr = max(env>>>1, MIN_THRESH). Uses env before this sample's update.
//  - cnt: increments per ready and saturates at MAX_INTVL. Cleared to 0 on the beat-confirming sample.
//  - FSM (transitions on ready):
//    SEARCH: y>thr -> TRACK, pk<=y.
//    TRACK: y>=pk -> pk<=y. y<pk -> beat confirmed; go to REFRACT with rcnt<=REFRACT-1.
//    REFRACT: rcnt==0 -> SEARCH, else rcnt--.
//  - Beat confirm: beat=1 on the clock after the confirming ready clock.
//    If have_prev: interval<=cnt+1 and interval_valid pulses with beat.
//    Then have_prev<=1 and no_signal<=0.
//  - First beat after reset or timeout: beat only; interval and bpm unchanged.
//  - Timeout: cnt reaches MAX_INTVL while in SEARCH or TRACK:
//    no_signal<=1, have_prev<=0, bpm_valid<=0, state<=SEARCH.
//    Sticky until the next beat.
//  - Divider: starts in the interval_valid clock and runs 16 cycles of restoring division
//    of 60*FS_HZ by interval.
//    bpm loads on clock +17 and bpm_valid<=1 there. Quotient>255 -> 255.
//  - A new start while the divider is busy cannot occur (REFRACT*32 >> 17 clocks).
//    If it does, the new start is ignored and the divide in flight completes.
//  - Simultaneous timeout and confirm: confirm wins. Timeout is unreachable in REFRACT.
//  - Reset mid-operation (any state, divider busy): returns to reset values.
//    No beat and no bpm update.
// STRUCTURE
//  - Package hr_pkg: FSM state enum {SEARCH,TRACK,REFRACT}; constant BPM_NUM=60*FS_HZ.
//  - Sub-module bpm_divider: 16-bit unsigned sequential divider.
//    Ports: start, dividend, divisor, busy, done, quotient.
//  - Everything else lives in this module.
// TESTING
//  - Reset with ready toggling, y=0: all outputs 0 and no beat for 599 samples.
//    At sample 600: no_signal=1.
//  - Triangle pulses, peak 1000, every 200 samples:
//    1 beat per pulse; 2nd beat gives interval=200.
//    17 clocks after that beat: bpm=60 and bpm_valid=1.
//  - Same train at a period of 150 samples: interval=150, bpm=80.
//    An extra 1000 pulse 30 samples after a beat produces no beat.
//  - After a locked train, y=0 for 600 samples: no_signal=1 and bpm_valid=0.
//    Next pulse gives a beat with no interval_valid.
//    The following pulse gives interval and bpm.
//  - Amplitude step 1000 -> 300 with a period of 200: beats resume by the 3rd small pulse
//    via envelope decay. Interval=200.
//  - Assert reset in TRACK and again during a divide: no beat, bpm stays 0.
//    Detection restarts cleanly afterwards.

Source files
------------

// File: rtl/hr_pkg.sv
// Shared types and constants for the heartbeat peak detector:
// detector FSM states, the BPM numerator and the BPM saturation helper.
package hr_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        TRACK   = 2'd1,
        REFRACT = 2'd2
    } hr_state_e;

    localparam int FS_HZ_DEFAULT = 200;
    localparam int BPM_NUM       = 60 * FS_HZ_DEFAULT;

    function automatic int bpm_num(input int fs_hz);
        return 60 * fs_hz;
    endfunction

    // The 8-bit rate output pins at 255 for very short intervals.
    function automatic logic [7:0] sat_bpm(input logic [15:0] quotient);
        if (quotient > 16'd255) begin
            return 8'd255;
        end else begin
            return quotient[7:0];
        end
    endfunction

endpackage

// File: rtl/bpm_divider.sv
// 16-bit unsigned restoring divider: 16 quotient bits over 16 clocks,
// the first bit resolved in the start clock; done pulses once when finished.
module bpm_divider (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient
);

    logic [15:0] rem_r;
    logic [15:0] quo_r;
    logic [15:0] dvs_r;
    logic [3:0]  step_r;
    logic        busy_r;
    logic        done_r;

    // One restoring step: returns {next remainder, next partial quotient}.
    function automatic logic [31:0] div_step(input logic [15:0] rem,
                                             input logic [15:0] quo,
                                             input logic [15:0] dvs);
        logic [16:0] trial;
        logic [16:0] diff;
        trial = {rem, quo[15]};
        diff  = trial - {1'b0, dvs};
        if (trial >= {1'b0, dvs}) begin
            return {diff[15:0], quo[14:0], 1'b1};
        end else begin
            return {trial[15:0], quo[14:0], 1'b0};
        end
    endfunction

    // Iteration state; a start while busy is ignored so the running divide completes.
    always_ff @(posedge clock) begin
        if (reset) begin
            rem_r  <= 16'd0;
            quo_r  <= 16'd0;
            dvs_r  <= 16'd0;
            step_r <= 4'd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (busy_r) begin
                {rem_r, quo_r} <= div_step(rem_r, quo_r, dvs_r);
                step_r         <= step_r + 4'd1;
                if (step_r == 4'd15) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
            end else if (start) begin
                {rem_r, quo_r} <= div_step(16'd0, dividend, divisor);
                dvs_r          <= divisor;
                step_r         <= 4'd1;
                busy_r         <= 1'b1;
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign quotient = quo_r;

endmodule

// File: rtl/beat_peak_detector.sv
// Heartbeat peak detector: adaptive-threshold peak search with a refractory
// window, beat-to-beat interval measurement and BPM computation.
module beat_peak_detector
    import hr_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int FS_HZ       = 200,
    parameter int REFRACT     = 60,
    parameter int MAX_INTVL   = 600,
    parameter int DECAY_SHIFT = 5,
    parameter int MIN_THRESH  = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ready,
    input  logic signed [DATA_W-1:0] y,
    output logic                     beat,
    output logic [15:0]              interval,
    output logic                     interval_valid,
    output logic [7:0]               bpm,
    output logic                     bpm_valid,
    output logic                     no_signal
);

    localparam int CNT_W  = $clog2(MAX_INTVL + 1);
    localparam int RCNT_W = (REFRACT > 1) ? $clog2(REFRACT) : 1;
    localparam logic [CNT_W-1:0]         CNT_MAX      = CNT_W'(MAX_INTVL);
    localparam logic [CNT_W-1:0]         CNT_LAST     = CNT_W'(MAX_INTVL - 1);
    localparam logic [RCNT_W-1:0]        RCNT_INIT    = RCNT_W'(REFRACT - 1);
    localparam logic signed [DATA_W-1:0] THR_FLOOR    = DATA_W'(MIN_THRESH);
    localparam logic [15:0]              BPM_DIVIDEND = 16'(bpm_num(FS_HZ));

    hr_state_e                state_r;
    hr_state_e                state_next_s;
    logic signed [DATA_W-1:0] env_r;
    logic signed [DATA_W-1:0] pk_r;
    logic signed [DATA_W-1:0] env_half_s;
    logic signed [DATA_W-1:0] thr_s;
    logic [CNT_W-1:0]         cnt_r;
    logic [RCNT_W-1:0]        rcnt_r;
    logic                     have_prev_r;
    logic                     rise_s;
    logic                     confirm_s;
    logic                     timeout_s;
    logic                     div_start_s;
    logic                     div_busy_s;
    logic                     div_done_s;
    logic [15:0]              div_quotient_s;

    // Detection threshold from the envelope as it stood before this sample.
    always_comb begin
        env_half_s = env_r >>> 1;
        if (env_half_s > THR_FLOOR) begin
            thr_s = env_half_s;
        end else begin
            thr_s = THR_FLOOR;
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= hr_pkg::SEARCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state; a timeout drops any search/track back to SEARCH.
    always_comb begin
        state_next_s = state_r;
        if (timeout_s) begin
            state_next_s = hr_pkg::SEARCH;
        end else begin
            case (state_r)
                hr_pkg::SEARCH: begin
                    if (rise_s) begin
                        state_next_s = hr_pkg::TRACK;
                    end else begin
                        state_next_s = hr_pkg::SEARCH;
                    end
                end
                hr_pkg::TRACK: begin
                    if (confirm_s) begin
                        state_next_s = hr_pkg::REFRACT;
                    end else begin
                        state_next_s = hr_pkg::TRACK;
                    end
                end
                hr_pkg::REFRACT: begin
                    if (ready && (rcnt_r == '0)) begin
                        state_next_s = hr_pkg::SEARCH;
                    end else begin
                        state_next_s = hr_pkg::REFRACT;
                    end
                end
                default: state_next_s = hr_pkg::SEARCH;
            endcase
        end
    end

    // FSM decode: rising edge of a pulse, confirmed peak, and interval timeout.
    always_comb begin
        rise_s    = 1'b0;
        confirm_s = 1'b0;
        case (state_r)
            hr_pkg::SEARCH:  rise_s    = ready && (y > thr_s);
            hr_pkg::TRACK:   confirm_s = ready && (y < pk_r);
            hr_pkg::REFRACT: confirm_s = 1'b0;
            default:         confirm_s = 1'b0;
        endcase
        // Only the step onto MAX_INTVL times out; a saturated count must not keep firing.
        if (ready && (state_r != hr_pkg::REFRACT) && (cnt_r == CNT_LAST) && !confirm_s) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Per-sample datapath: envelope, peak hold, interval and refractory counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            env_r       <= '0;
            pk_r        <= '0;
            cnt_r       <= '0;
            rcnt_r      <= '0;
            have_prev_r <= 1'b0;
        end else if (ready) begin
            if (y > env_r) begin
                env_r <= y;
            end else begin
                env_r <= env_r - (env_r >>> DECAY_SHIFT);
            end
            if (rise_s || ((state_r == hr_pkg::TRACK) && (y >= pk_r))) begin
                pk_r <= y;
            end
            if (confirm_s) begin
                cnt_r <= '0;
            end else if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + 1'b1;
            end
            if (confirm_s) begin
                rcnt_r <= RCNT_INIT;
            end else if ((state_r == hr_pkg::REFRACT) && (rcnt_r != '0)) begin
                rcnt_r <= rcnt_r - 1'b1;
            end
            if (confirm_s) begin
                have_prev_r <= 1'b1;
            end else if (timeout_s) begin
                have_prev_r <= 1'b0;
            end
        end
    end

    // Registered outputs; the interval counts the confirming sample itself.
    always_ff @(posedge clock) begin
        if (reset) begin
            beat           <= 1'b0;
            interval       <= 16'd0;
            interval_valid <= 1'b0;
            bpm            <= 8'd0;
            bpm_valid      <= 1'b0;
            no_signal      <= 1'b0;
        end else begin
            beat           <= confirm_s;
            interval_valid <= confirm_s && have_prev_r;
            if (confirm_s && have_prev_r) begin
                interval <= 16'(cnt_r) + 16'd1;
            end
            if (confirm_s) begin
                no_signal <= 1'b0;
            end else if (timeout_s) begin
                no_signal <= 1'b1;
            end
            if (timeout_s) begin
                bpm_valid <= 1'b0;
            end else if (div_done_s) begin
                bpm_valid <= 1'b1;
            end
            if (div_done_s) begin
                bpm <= sat_bpm(div_quotient_s);
            end
        end
    end

    assign div_start_s = interval_valid && !div_busy_s;

    bpm_divider u_bpm_divider (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start_s),
        .dividend (BPM_DIVIDEND),
        .divisor  (interval),
        .busy     (div_busy_s),
        .done     (div_done_s),
        .quotient (div_quotient_s)
    );

endmodule

// File: tb/tb_beat_peak_detector.sv
// Self-checking bench for beat_peak_detector: a pulse-train vector table plus
// hand sequences for timeout and reset; expected beats go through a scoreboard queue.
module tb_beat_peak_detector;

    logic               clock = 1'b0;
    logic               reset;
    logic               ready;
    logic signed [15:0] y;
    logic               beat;
    logic [15:0]        interval;
    logic               interval_valid;
    logic [7:0]         bpm;
    logic               bpm_valid;
    logic               no_signal;

    always #5 clock = ~clock;

    beat_peak_detector dut (
        .clock          (clock),
        .reset          (reset),
        .ready          (ready),
        .y              (y),
        .beat           (beat),
        .interval       (interval),
        .interval_valid (interval_valid),
        .bpm            (bpm),
        .bpm_valid      (bpm_valid),
        .no_signal      (no_signal)
    );

    typedef struct {
        int   smp;
        logic ivalid;
        int   intv;
        logic chk_bpm;
        int   bpm_val;
    } exp_beat_t;

    typedef struct {
        int   gap;
        int   amp;
        logic pre_nosig;
        logic pre_bval;
        logic exp_beat;
        logic exp_iv;
        int   exp_intv;
        int   exp_bpm;
    } vec_t;

    exp_beat_t exp_q[$];
    exp_beat_t cur_e;
    int        n_checks     = 0;
    int        n_fail       = 0;
    int        sample_idx   = 0;
    int        bpm_due      = 0;
    int        bpm_due_val  = 0;
    int        bpm_prev_exp = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (sample %0d)", name, act, exp, sample_idx);
        end
    endtask

    function automatic int tri_val(input int amp, input int i);
        if (i < 8) return (amp * (i + 1)) / 8;
        else       return (amp * (15 - i)) / 8;
    endfunction

    task automatic send_sample(input int val);
        @(negedge clock);
        ready = 1'b1;
        y     = 16'(val);
        sample_idx++;
        @(negedge clock);
        ready = 1'b0;
        y     = 16'sd0;
        repeat (30) @(negedge clock);
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) send_sample(0);
    endtask

    // Sends the first n samples of a triangle; the peak is confirmed on sample index 8.
    task automatic send_pulse(input int amp, input int n, input logic exp_b, input logic iv,
                              input int intv, input logic cb, input int bv);
        for (int i = 0; i < n; i++) begin
            if (i == 8 && exp_b) exp_q.push_back('{sample_idx + 1, iv, intv, cb, bv});
            send_sample(tri_val(amp, i));
        end
    endtask

    // Scoreboard: match each beat against the queue and time the bpm update.
    always @(negedge clock) begin
        if (bpm_due > 0) begin
            bpm_due--;
            if (bpm_due == 1) check("bpm_before_load", int'(bpm), bpm_prev_exp);
            if (bpm_due == 0) begin
                check("bpm", int'(bpm), bpm_due_val);
                check("bpm_valid", int'(bpm_valid), 1);
                bpm_prev_exp = bpm_due_val;
            end
        end
        if (beat === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got beat=1, expected none (sample %0d)", sample_idx);
            end else begin
                cur_e = exp_q.pop_front();
                check("beat_sample", sample_idx, cur_e.smp);
                check("interval_valid", int'(interval_valid), int'(cur_e.ivalid));
                if (cur_e.ivalid) check("interval", int'(interval), cur_e.intv);
                if (cur_e.chk_bpm) begin
                    bpm_due     = 17;
                    bpm_due_val = cur_e.bpm_val;
                end
            end
        end else if (interval_valid !== 1'b0) begin
            n_checks++;
            n_fail++;
            $display("FAIL interval_valid_without_beat: got %b, expected 0", interval_valid);
        end
    end

    initial begin
        vec_t vecs[7];
        // gap, amp, pre no_signal, pre bpm_valid, beat, interval_valid, interval, bpm
        vecs[0] = '{20,  1000, 1'b1, 1'b0, 1'b1, 1'b0, 0,   0};
        vecs[1] = '{185, 1000, 1'b0, 1'b0, 1'b1, 1'b1, 200, 60};
        vecs[2] = '{135, 1000, 1'b0, 1'b1, 1'b1, 1'b1, 150, 80};
        vecs[3] = '{23,  1000, 1'b0, 1'b1, 1'b0, 1'b0, 0,   0};
        vecs[4] = '{647, 1000, 1'b1, 1'b0, 1'b1, 1'b0, 0,   0};
        vecs[5] = '{185, 1000, 1'b0, 1'b0, 1'b1, 1'b1, 200, 60};
        vecs[6] = '{185, 300,  1'b0, 1'b1, 1'b1, 1'b1, 200, 60};

        reset = 1'b1;
        ready = 1'b0;
        y     = 16'sd0;
        repeat (3) begin
            @(negedge clock); ready = 1'b1;
            @(negedge clock); ready = 1'b0;
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_beat", int'(beat), 0);
        check("reset_interval", int'(interval), 0);
        check("reset_interval_valid", int'(interval_valid), 0);
        check("reset_bpm", int'(bpm), 0);
        check("reset_bpm_valid", int'(bpm_valid), 0);
        check("reset_no_signal", int'(no_signal), 0);

        send_zeros(599);
        check("no_signal_at_599", int'(no_signal), 0);
        send_sample(0);
        check("no_signal_at_600", int'(no_signal), 1);
        check("bpm_valid_at_600", int'(bpm_valid), 0);

        for (int v = 0; v < 7; v++) begin
            send_zeros(vecs[v].gap);
            check("pre_no_signal", int'(no_signal), int'(vecs[v].pre_nosig));
            check("pre_bpm_valid", int'(bpm_valid), int'(vecs[v].pre_bval));
            check("pre_bpm", int'(bpm), bpm_prev_exp);
            send_pulse(vecs[v].amp, 15, vecs[v].exp_beat, vecs[v].exp_iv,
                       vecs[v].exp_intv, vecs[v].exp_iv, vecs[v].exp_bpm);
        end
        send_zeros(50);

        // Reset while tracking the rising edge of a pulse.
        send_pulse(1000, 4, 1'b0, 1'b0, 0, 1'b0, 0);
        @(negedge clock); reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        bpm_prev_exp = 0;
        @(negedge clock);
        check("rst_track_bpm", int'(bpm), 0);
        check("rst_track_bpm_valid", int'(bpm_valid), 0);
        check("rst_track_interval", int'(interval), 0);
        send_zeros(30);

        // Reset while the divider is working on a 100-sample interval.
        send_pulse(1000, 15, 1'b1, 1'b0, 0, 1'b0, 0);
        send_zeros(85);
        send_pulse(1000, 8, 1'b0, 1'b0, 0, 1'b0, 0);
        exp_q.push_back('{sample_idx + 1, 1'b1, 100, 1'b0, 0});
        @(negedge clock); ready = 1'b1; y = 16'(tri_val(1000, 8)); sample_idx++;
        @(negedge clock); ready = 1'b0; y = 16'sd0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("rst_div_bpm", int'(bpm), 0);
        check("rst_div_bpm_valid", int'(bpm_valid), 0);
        check("rst_div_interval", int'(interval), 0);
        send_zeros(20);

        // Detection restarts cleanly: first beat alone, then interval 100 -> 120 bpm.
        send_pulse(1000, 15, 1'b1, 1'b0, 0, 1'b0, 0);
        send_zeros(85);
        send_pulse(1000, 15, 1'b1, 1'b1, 100, 1'b1, 120);
        send_zeros(30);

        check("pending_beats", exp_q.size(), 0);
        check("pending_bpm_check", bpm_due, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
